// File: rtl/program_loader_if.sv
// Byte-stream in / memory-write-port out bundle for the boot loader.
// The loader takes the slave side; whoever feeds bytes and watches the memory port takes master.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_data, cpu_hold, load_done, load_error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_data, cpu_hold, load_done, load_error
    );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream boot loader: SYNC, COUNT_HI, COUNT_LO, 4*N data bytes, XOR checksum.
// Writes the image word by word into instruction memory and holds the CPU until a good frame lands.
module program_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic           clk,
    input  logic           reset,
    program_loader_if.slave bus
);
    localparam int unsigned     TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_e;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

    state_e            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [7:0]        chk_q, chk_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rx_ready_q, rx_ready_d;
    logic              we_q, we_d;

    logic              accept_s;
    logic              in_frame_s;
    logic [15:0]       count_s;

    assign accept_s   = bus.rx_valid & rx_ready_q;
    assign count_s    = {cnt_hi_q, bus.rx_data};
    assign in_frame_s = (state_q == CNT_HI) || (state_q == CNT_LO) || (state_q == DATA) ||
                        (state_q == WRITE)  || (state_q == CHECK);

    // Next-state and next-output decode for the frame parser.
    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        words_d    = words_q;
        byte_idx_d = byte_idx_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        chk_d      = chk_q;
        tmo_d      = tmo_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (accept_s && (bus.rx_data == SYNC_BYTE)) begin
                    state_d    = CNT_HI;
                    hold_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    mem_addr_d = '0;
                    chk_d      = 8'h00;
                    byte_idx_d = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            CNT_HI: begin
                if (accept_s) begin
                    cnt_hi_d = bus.rx_data;
                    state_d  = CNT_LO;
                end else begin
                    state_d = CNT_HI;
                end
            end
            CNT_LO: begin
                if (accept_s) begin
                    if ((count_s == 16'd0) || ({1'b0, count_s} > MAX_WORDS)) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        words_d    = (ADDR_W + 1)'(count_s);
                        byte_idx_d = 2'd0;
                        state_d    = DATA;
                    end
                end else begin
                    state_d = CNT_LO;
                end
            end
            DATA: begin
                if (accept_s) begin
                    mem_data_d = {mem_data_q[23:0], bus.rx_data};
                    chk_d      = chk_update(chk_q, bus.rx_data);
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            WRITE: begin
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                words_d    = words_q - (ADDR_W + 1)'(1);
                if (words_q == (ADDR_W + 1)'(1)) begin
                    state_d = CHECK;
                end else begin
                    state_d = DATA;
                end
            end
            CHECK: begin
                if (accept_s) begin
                    if (bus.rx_data == chk_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = CHECK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Inter-byte watchdog overrides any in-frame transition.
        if (in_frame_s) begin
            if (accept_s) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = ERROR;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end

        rx_ready_d = (state_d != WRITE);
        we_d       = (state_d == WRITE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_hi_q   <= 8'h00;
            words_q    <= '0;
            byte_idx_q <= 2'd0;
            mem_addr_q <= '0;
            mem_data_q <= 32'h0000_0000;
            chk_q      <= 8'h00;
            tmo_q      <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b1;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_hi_q   <= cnt_hi_d;
            words_q    <= words_d;
            byte_idx_q <= byte_idx_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            chk_q      <= chk_d;
            tmo_q      <= tmo_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_done  = done_q;
    assign bus.load_error = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized frame-level bench for program_loader: a byte-stream sender plus a write monitor,
// checked against expected images and frame outcomes derived from the framing rules.
module tb_program_loader;
    localparam int unsigned ADDR_W = 10;

    logic clk;
    logic reset;

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    program_loader #(
        .ADDR_W(ADDR_W),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] wr_a[$];
    logic [31:0]       wr_d[$];
    logic [31:0]       exp_w[$];
    int                viol = 0;
    logic              prev_we = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: logs every strobe; flags rx_ready/mem_we disagreement or multi-cycle strobes.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_data);
        end
        viol    <= viol + int'(bus.rx_ready == bus.mem_we) + int'(bus.mem_we && prev_we);
        prev_we <= bus.mem_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w >= 8) check("rdy_stuck", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int g);
        if (g > 0) begin
            bus.rx_valid = 1'b0;
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_status(input string tag, input bit done, input bit err, input bit hold);
        check({tag, "_done"}, 32'(bus.load_done), 32'(done));
        check({tag, "_err"},  32'(bus.load_error), 32'(err));
        check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(hold));
    endtask

    // Sends one frame carrying exp_w[0..n-1]; optionally spoils the checksum.
    task automatic run_frame(input string tag, input int n, input bit corrupt, input int maxg);
        logic [7:0]  c;
        logic [7:0]  b;
        logic [15:0] nn;
        logic [31:0] w;
        int          base_w;
        int          base_v;
        c      = 8'h00;
        nn     = 16'(n);
        base_w = wr_a.size();
        base_v = viol;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
            gap($urandom_range(0, maxg));
        end
        send_byte(8'hA5);
        check_status({tag, "_sync"}, 1'b0, 1'b0, 1'b1);
        send_byte(nn[15:8]);
        send_byte(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = exp_w[i];
            for (int j = 0; j < 4; j++) begin
                b = 8'(w >> (24 - 8 * j));
                c = c ^ b;
                send_byte(b);
                gap($urandom_range(0, maxg));
            end
        end
        if (corrupt) c = c ^ 8'(8'd1 << $urandom_range(0, 7));
        send_byte(c);
        bus.rx_valid = 1'b0;
        check_status(tag, !corrupt, corrupt, corrupt);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_nwr"}, 32'(wr_a.size() - base_w), 32'(n));
        for (int i = 0; i < n && (base_w + i) < wr_a.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_a[base_w + i]), 32'(i));
            check({tag, "_data"}, wr_d[base_w + i], exp_w[i]);
        end
        check({tag, "_viol"}, 32'(viol - base_v), 32'd0);
    endtask

    task automatic run_badcount(input string tag, input logic [15:0] nn);
        int base_w;
        base_w = wr_a.size();
        send_byte(8'hA5);
        send_byte(nn[15:8]);
        send_byte(nn[7:0]);
        bus.rx_valid = 1'b0;
        check_status(tag, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_nwr"}, 32'(wr_a.size() - base_w), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base_w;
        int w;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_we",    32'(bus.mem_we), 32'd0);
        check("rst_addr",  32'(bus.mem_addr), 32'd0);
        check("rst_data",  bus.mem_data, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Reference two-word image, good and bad checksum
        exp_w.delete();
        exp_w.push_back(32'h1122_3344);
        exp_w.push_back(32'hDEAD_BEEF);
        run_frame("t1", 2, 1'b0, 1);
        run_frame("t2", 2, 1'b1, 1);

        run_badcount("cnt0", 16'h0000);
        run_badcount("cnt401", 16'h0401);

        // Stall mid-frame after two data bytes
        base_w = wr_a.size();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        bus.rx_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("tmo_early", 32'(bus.load_error), 32'd0);
        @(posedge clk);
        #1;
        check_status("tmo", 1'b0, 1'b1, 1'b1);
        check("tmo_nwr", 32'(wr_a.size() - base_w), 32'd0);

        // Continuous rx_valid across WRITE cycles
        exp_w.delete();
        repeat (4) exp_w.push_back($urandom);
        run_frame("cont", 4, 1'b0, 0);

        // Reset after the first word is written
        exp_w.delete();
        exp_w.push_back($urandom);
        exp_w.push_back($urandom);
        base_w = wr_a.size();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        for (int j = 0; j < 4; j++) send_byte(8'(exp_w[0] >> (24 - 8 * j)));
        bus.rx_valid = 1'b0;
        w = 0;
        while (wr_a.size() == base_w && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("mid_nwr", 32'(wr_a.size() - base_w), 32'd1);
        if (wr_a.size() > base_w) check("mid_data", wr_d[base_w], exp_w[0]);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_ready", 32'(bus.rx_ready), 32'd1);
        check("mrst_we",    32'(bus.mem_we), 32'd0);
        check("mrst_addr",  32'(bus.mem_addr), 32'd0);
        check("mrst_data",  bus.mem_data, 32'd0);
        check_status("mrst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        exp_w.delete();
        repeat (3) exp_w.push_back($urandom);
        run_frame("after_rst", 3, 1'b0, 2);

        // Sync value as ordinary data
        exp_w.delete();
        exp_w.push_back(32'hA5A5_A5A5);
        run_frame("syncdata", 1, 1'b0, 0);

        // Random frames
        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(1, 6);
            exp_w.delete();
            repeat (n) exp_w.push_back($urandom);
            run_frame("rnd", n, ($urandom_range(0, 2) == 0), 3);
        end

        // Largest legal image
        exp_w.delete();
        repeat (1024) exp_w.push_back($urandom);
        run_frame("max", 1024, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
